// File: rtl/freq_pkg.sv
// freq_pkg: shared FSM state encoding and gate-counter width helper
package freq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    function automatic int gate_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer with history flop producing a single-cycle rise pulse
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic arm_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    // hist tracks sync_out every cycle, so after the arm cycle a level that is
    // already high cannot look like an edge; the arm cycle itself never reports one
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync[SYNC_STAGES-1] & ~hist & ~arm_i;

endmodule

// File: rtl/freq_gate_counter.sv
// freq_gate_counter: counts test_signal rising edges over a fixed clk gate and latches the result
module freq_gate_counter
    import freq_pkg::*;
#(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             test_signal,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] dout,
    output logic             overflow
);

    localparam int GW = gate_w(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             at_max;
    logic             rise;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (test_signal),
        .arm_i  (state == ARM),
        .rise_o (rise)
    );

    // next-count values are shared by the running counter and the final latch,
    // so a rise in the last gate cycle still lands in dout
    always_comb begin
        at_max   = &edge_cnt;
        edge_nxt = (rise && !at_max) ? edge_cnt + 1'b1 : edge_cnt;
        sat_nxt  = sat | (rise & at_max);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            overflow <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                    state    <= GATE;
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 1'b1;
                    edge_cnt <= edge_nxt;
                    sat      <= sat_nxt;
                    if (gate_cnt == LAST) begin
                        state    <= LATCH;
                        done     <= 1'b1;
                        dout     <= edge_nxt;
                        overflow <= sat_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
